// File: rtl/pfvf_rtable_pkg.sv
// ---------------------------------------------------------------------------
// pfvf_rtable_pkg
// Shared types and widths for the PF/VF routing-table lookup block.
//   PF_W / VF_W     : requester physical / virtual function ID widths.
//   ENTRY_PID_W     : stored port-ID field width. The wide field lets one entry
//                     format serve every NUM_PORTS up to 32. The lookup uses
//                     only the low PID_W bits.
//   t_rtable_entry  : one routing-table entry.
//   t_rtable_array  : a full-size table view (MAX_ENTRIES entries), intended
//                     for software models and register maps.
// ---------------------------------------------------------------------------
package pfvf_rtable_pkg;

  localparam int PF_W        = 3;
  localparam int VF_W        = 11;
  localparam int ENTRY_PID_W = 5;
  localparam int MAX_ENTRIES = 32;

  typedef struct packed {
    logic                   en;
    logic [PF_W-1:0]        pf;
    logic [VF_W-1:0]        vf;
    logic                   vf_active;
    logic                   any_vf;      // wildcard over every VF of this PF
    logic [ENTRY_PID_W-1:0] pid;
  } t_rtable_entry;

  typedef t_rtable_entry [MAX_ENTRIES-1:0] t_rtable_array;

endpackage

// File: rtl/pfvf_rtable_match.sv
// ---------------------------------------------------------------------------
// pfvf_rtable_match
// Purely combinational comparison of one lookup request against every table
// entry. This block performs no priority resolution.
// Ports:
//   lkp_pf, lkp_vf, lkp_vf_active : requester function ID.
//   table_q                       : current table contents.
//   match_vec                     : bit i is set when entry i matches.
// ---------------------------------------------------------------------------
module pfvf_rtable_match
  import pfvf_rtable_pkg::*;
#(
  parameter int NUM_ENTRIES = 6
) (
  input  logic [PF_W-1:0]        lkp_pf,
  input  logic [VF_W-1:0]        lkp_vf,
  input  logic                   lkp_vf_active,
  input  t_rtable_entry          table_q [NUM_ENTRIES],
  output logic [NUM_ENTRIES-1:0] match_vec
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      t_rtable_entry          ent;
      logic [ENTRY_PID_W-1:0] unused_pid;

      assign ent        = table_q[gi];
      assign unused_pid = ent.pid;
      // A PF-only entry (vf_active=0) never compares the VF field.
      // The any_vf bit widens a VF entry to every VF of its PF.
      assign match_vec[gi] = ent.en
                          && (ent.pf == lkp_pf)
                          && (ent.vf_active == lkp_vf_active)
                          && (!ent.vf_active || ent.any_vf || (ent.vf == lkp_vf));
    end
  endgenerate

endmodule

// File: rtl/pfvf_rtable_lookup.sv
// ---------------------------------------------------------------------------
// pfvf_rtable_lookup
// PF/VF routing-table lookup with a two-stage valid/ready pipeline.
//   S1 captures the match vector, each entry's port ID and the tag.
//   S2 holds the priority-encoded result. The lowest index wins.
//   A request presented in cycle N, and accepted at the end of cycle N,
//   returns its result in cycle N+2. Throughput is one lookup per cycle.
// Ports:
//   clk, rst_n              : clock and asynchronous active-low reset.
//   lkp_*                   : lookup request (valid/ready, PF, VF, vf_active, tag).
//   res_*                   : result (valid/ready, pid, hit, idx, tag).
//   cfg_wr/cfg_idx/cfg_entry: table write port. Out-of-range indices are ignored.
//   stats_clr, hit_cnt, miss_cnt : saturating lookup statistics.
// Build option: define PFVF_RTABLE_STATS_EN to build the hit/miss counters.
// Without it, both counters read 0 and stats_clr is ignored.
// ---------------------------------------------------------------------------
module pfvf_rtable_lookup
  import pfvf_rtable_pkg::*;
#(
  parameter int  NUM_ENTRIES = 6,
  parameter int  NUM_PORTS   = 4,
  parameter int  DEF_PID     = 0,
  parameter int  TAG_W       = 8,
  localparam int PID_W       = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lkp_valid,
  output logic              lkp_ready,
  input  logic [PF_W-1:0]   lkp_pf,
  input  logic [VF_W-1:0]   lkp_vf,
  input  logic              lkp_vf_active,
  input  logic [TAG_W-1:0]  lkp_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PID_W-1:0]  res_pid,
  output logic              res_hit,
  output logic [IDX_W-1:0]  res_idx,
  output logic [TAG_W-1:0]  res_tag,
  input  logic              cfg_wr,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  t_rtable_entry     cfg_entry,
  input  logic              stats_clr,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  // ---------------- routing table ----------------
  t_rtable_entry                      table_reg [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]             entry_we;
  logic [NUM_ENTRIES-1:0][PID_W-1:0]  entry_pid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      // cfg_idx values at or above NUM_ENTRIES never equal any gi,
      // so those writes are dropped.
      assign entry_we[gi]  = cfg_wr && (cfg_idx == IDX_W'(gi));
      assign entry_pid[gi] = table_reg[gi].pid[PID_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (entry_we[i]) table_reg[i] <= cfg_entry;
      end
    end
  end

  logic [NUM_ENTRIES-1:0] match_vec;

  pfvf_rtable_match #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_match (
    .lkp_pf        (lkp_pf),
    .lkp_vf        (lkp_vf),
    .lkp_vf_active (lkp_vf_active),
    .table_q       (table_reg),
    .match_vec     (match_vec)
  );

  // ---------------- pipeline control ----------------
  logic                              s1_valid_reg;
  logic [NUM_ENTRIES-1:0]            s1_match_reg;
  logic [NUM_ENTRIES-1:0][PID_W-1:0] s1_pid_reg;
  logic [TAG_W-1:0]                  s1_tag_reg;
  logic                              s2_valid_reg;
  logic                              s2_hit_reg;
  logic [IDX_W-1:0]                  s2_idx_reg;
  logic [PID_W-1:0]                  s2_pid_reg;
  logic [TAG_W-1:0]                  s2_tag_reg;
  logic                              s2_ready;
  logic                              s1_load;

  assign s2_ready  = !s2_valid_reg || res_ready;
  assign lkp_ready = !s1_valid_reg || s2_ready;
  assign s1_load   = lkp_valid && lkp_ready;

  // Port IDs are snapshotted together with the match vector. A table write
  // after acceptance therefore cannot change an in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_match_reg <= '0;
      s1_pid_reg   <= '0;
      s1_tag_reg   <= '0;
    end else begin
      if (lkp_ready) s1_valid_reg <= lkp_valid;
      if (s1_load) begin
        s1_match_reg <= match_vec;
        s1_pid_reg   <= entry_pid;
        s1_tag_reg   <= lkp_tag;
      end
    end
  end

  // ---------------- priority encoder ----------------
  logic             enc_hit_next;
  logic [IDX_W-1:0] enc_idx_next;
  logic [PID_W-1:0] enc_pid_next;

  always_comb begin
    enc_hit_next = |s1_match_reg;
    enc_idx_next = '0;
    enc_pid_next = PID_W'(DEF_PID);
    // Scan high to low so the lowest matching index is the last one written.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (s1_match_reg[i]) begin
        enc_idx_next = IDX_W'(i);
        enc_pid_next = s1_pid_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_hit_reg   <= 1'b0;
      s2_idx_reg   <= '0;
      s2_pid_reg   <= '0;
      s2_tag_reg   <= '0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_hit_reg <= enc_hit_next;
        s2_idx_reg <= enc_idx_next;
        s2_pid_reg <= enc_pid_next;
        s2_tag_reg <= s1_tag_reg;
      end
    end
  end

  assign res_valid = s2_valid_reg;
  assign res_hit   = s2_hit_reg;
  assign res_idx   = s2_idx_reg;
  assign res_pid   = s2_pid_reg;
  assign res_tag   = s2_tag_reg;

  // ---------------- statistics ----------------
`ifdef PFVF_RTABLE_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  logic        res_fire;

  assign res_fire = s2_valid_reg && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (stats_clr) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (res_fire) begin
      if (s2_hit_reg) begin
        if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign hit_cnt          = '0;
  assign miss_cnt         = '0;
`endif

endmodule

// File: tb/tb_pfvf_rtable_lookup.sv
module tb_pfvf_rtable_lookup;
  import pfvf_rtable_pkg::*;

  localparam int NE  = 6;
  localparam int NP  = 4;
  localparam int DEF = 0;
  localparam int TW  = 8;
  localparam int PW  = 2;
  localparam int IW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lkp_valid, lkp_ready, lkp_vf_active;
  logic [PF_W-1:0]   lkp_pf;
  logic [VF_W-1:0]   lkp_vf;
  logic [TW-1:0]     lkp_tag;
  logic              res_valid, res_ready, res_hit;
  logic [PW-1:0]     res_pid;
  logic [IW-1:0]     res_idx;
  logic [TW-1:0]     res_tag;
  logic              cfg_wr;
  logic [IW-1:0]     cfg_idx;
  t_rtable_entry     cfg_entry;
  logic              stats_clr;
  logic [31:0]       hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  pfvf_rtable_lookup #(
    .NUM_ENTRIES (NE), .NUM_PORTS (NP), .DEF_PID (DEF), .TAG_W (TW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .lkp_valid (lkp_valid), .lkp_ready (lkp_ready),
    .lkp_pf (lkp_pf), .lkp_vf (lkp_vf), .lkp_vf_active (lkp_vf_active), .lkp_tag (lkp_tag),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_pid (res_pid), .res_hit (res_hit), .res_idx (res_idx), .res_tag (res_tag),
    .cfg_wr (cfg_wr), .cfg_idx (cfg_idx), .cfg_entry (cfg_entry),
    .stats_clr (stats_clr), .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
  );

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [PW-1:0] pid;
    logic [TW-1:0] tag;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  exp_t          expq[$];
  t_rtable_entry mtab [NE];
  logic [31:0]   m_hit, m_miss;
  bit            ready_low_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first enabled entry (lowest index) satisfying the match rule.
  function automatic exp_t model(input logic [PF_W-1:0] pf, input logic [VF_W-1:0] vf,
                                 input logic act, input logic [TW-1:0] tag);
    exp_t r;
    r.hit = 1'b0; r.idx = '0; r.pid = PW'(DEF); r.tag = tag;
    for (int i = 0; i < NE; i++) begin
      if (!r.hit && mtab[i].en && mtab[i].pf == pf && mtab[i].vf_active == act &&
          (!act || mtab[i].any_vf || mtab[i].vf == vf)) begin
        r.hit = 1'b1; r.idx = IW'(i); r.pid = mtab[i].pid[PW-1:0];
      end
    end
    return r;
  endfunction

  function automatic t_rtable_entry mk(input logic en, input int pf, input int vf,
                                       input logic act, input logic any, input int pid);
    t_rtable_entry e;
    e.en = en; e.pf = PF_W'(pf); e.vf = VF_W'(vf); e.vf_active = act;
    e.any_vf = any; e.pid = ENTRY_PID_W'(pid);
    return e;
  endfunction

  // One clock: score the current outputs, model the edge, advance, check counters.
  task automatic tick();
    bit   acc, take;
    exp_t e;
    #1;
    acc  = lkp_valid && lkp_ready;
    take = res_valid && res_ready;
    if (!lkp_ready) ready_low_seen = 1'b1;
    if (res_valid) begin
      if (expq.size() == 0) check("res_unexpected", res_valid, 0);
      else begin
        e = expq[0];
        check("res_hit", res_hit, e.hit);
        check("res_idx", res_idx, e.idx);
        check("res_pid", res_pid, e.pid);
        check("res_tag", res_tag, e.tag);
        if (take) begin
          $display("RES tag=%02h hit=%0d idx=%0d pid=%0d", res_tag, res_hit, res_idx, res_pid);
          void'(expq.pop_front());
        end
      end
    end
    if (acc) expq.push_back(model(lkp_pf, lkp_vf, lkp_vf_active, lkp_tag));
    if (cfg_wr && int'(cfg_idx) < NE) mtab[cfg_idx] = cfg_entry;
    if (stats_clr) begin
      m_hit = '0; m_miss = '0;
    end else if (take) begin
      if (res_hit) begin if (m_hit != 32'hFFFF_FFFF) m_hit++; end
      else begin if (m_miss != 32'hFFFF_FFFF) m_miss++; end
    end
    @(posedge clk); #1;
`ifdef PFVF_RTABLE_STATS_EN
    check("hit_cnt", hit_cnt, m_hit);
    check("miss_cnt", miss_cnt, m_miss);
`else
    check("hit_cnt_tied", hit_cnt, 0);
    check("miss_cnt_tied", miss_cnt, 0);
`endif
  endtask

  task automatic idle();
    lkp_valid = 1'b0; cfg_wr = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic wr(input int idx, input t_rtable_entry e);
    cfg_wr = 1'b1; cfg_idx = IW'(idx); cfg_entry = e;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic lkp(input int pf, input int vf, input logic act, input int tag);
    lkp_valid = 1'b1; lkp_pf = PF_W'(pf); lkp_vf = VF_W'(vf);
    lkp_vf_active = act; lkp_tag = TW'(tag);
  endtask

  task automatic drain();
    idle(); res_ready = 1'b1;
    for (int i = 0; i < 40 && (expq.size() != 0 || res_valid); i++) tick();
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    int sent;
    int c;
    exp_t reqs [8];
    rst_n = 1'b0; idle(); res_ready = 1'b1;
    lkp_pf = '0; lkp_vf = '0; lkp_vf_active = 1'b0; lkp_tag = '0;
    cfg_idx = '0; cfg_entry = '0;
    for (int i = 0; i < NE; i++) mtab[i] = '0;
    m_hit = '0; m_miss = '0; ready_low_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_lkp_ready", lkp_ready, 1);
    rst_n = 1'b1;
    #1;
    check("post_rst_lkp_ready", lkp_ready, 1);
    check("post_rst_hit_cnt", hit_cnt, 0);
    check("post_rst_miss_cnt", miss_cnt, 0);

    // Basic hit through a VF entry, with latency.
    wr(0, mk(1, 0, 0, 0, 0, 0));
    wr(1, mk(1, 0, 3, 1, 0, 2));
    lkp(0, 3, 1, 'h5A);
    tick();
    lkp_valid = 1'b0;
    check("lat_not_early", res_valid, 0);
    tick();
    check("lat_valid", res_valid, 1);
    check("b_pid", res_pid, 2);
    check("b_hit", res_hit, 1);
    check("b_idx", res_idx, 1);
    check("b_tag", res_tag, 'h5A);
    drain();

    // Lowest index wins: any_vf entry2 beats exact entry4.
    wr(2, mk(1, 0, 0, 1, 1, 1));
    wr(4, mk(1, 0, 7, 1, 0, 3));
    lkp(0, 7, 1, 'h11);
    tick(); lkp_valid = 1'b0; tick();
    check("prio_idx", res_idx, 2);
    check("prio_pid", res_pid, 1);
    drain();

    // Miss returns DEF_PID.
    lkp(5, 0, 0, 'h22);
    tick(); lkp_valid = 1'b0; tick();
    check("miss_hit", res_hit, 0);
    check("miss_pid", res_pid, DEF);
    check("miss_idx", res_idx, 0);
    drain();
`ifdef PFVF_RTABLE_STATS_EN
    check("miss_cnt_one", miss_cnt, 1);
`endif

    // Eight back-to-back lookups, res_ready low in cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      reqs[i].hit = 1'b0; reqs[i].idx = '0; reqs[i].pid = '0;
      reqs[i].tag = TW'('h80 + i);
    end
    sent = 0; ready_low_seen = 1'b0;
    for (c = 0; c < 60 && (sent < 8 || expq.size() != 0); c++) begin
      res_ready = !(c >= 3 && c <= 6);
      if (sent < 8) lkp($urandom_range(0, 1), $urandom_range(0, 8), 1'($urandom_range(0, 1)), int'(reqs[sent].tag));
      else lkp_valid = 1'b0;
      #1;
      if (lkp_valid && lkp_ready) sent++;
      tick();
    end
    check("b2b_all_sent", sent, 8);
    check("b2b_ready_dropped", ready_low_seen, 1);
    drain();

    // Write in the same cycle as a lookup: old contents apply.
    wr(2, mk(0, 0, 0, 1, 1, 1));
    cfg_wr = 1'b1; cfg_idx = 3'd1; cfg_entry = mk(0, 0, 3, 1, 0, 2);
    lkp(0, 3, 1, 'h39);
    tick();
    cfg_wr = 1'b0; lkp(0, 3, 1, 'h3A);
    tick();
    lkp_valid = 1'b0;
    check("wr_same_hit", res_hit, 1);
    check("wr_same_idx", res_idx, 1);
    tick();
    check("wr_next_hit", res_hit, 0);
    check("wr_next_pid", res_pid, DEF);
    drain();

    // Out-of-range write must not alter the table.
    wr(7, mk(1, 0, 0, 0, 0, 3));
    lkp(0, 0, 0, 'h44);
    tick(); lkp_valid = 1'b0; tick();
    check("oor_idx", res_idx, 0);
    check("oor_pid", res_pid, 0);
    drain();

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      lkp($urandom_range(0, 2), $urandom_range(0, 7), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      lkp_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      cfg_wr    = ($urandom_range(0, 4) == 0);
      cfg_idx   = IW'($urandom_range(0, 7));
      cfg_entry = mk($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      stats_clr = ($urandom_range(0, 40) == 0);
      tick();
    end
    drain();

    // Reset with two lookups in flight.
    wr(3, mk(1, 6, 0, 0, 0, 3));
    res_ready = 1'b0;
    lkp(6, 0, 0, 'hA1); tick();
    lkp(6, 0, 0, 'hA2); tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_lkp_ready", lkp_ready, 1);
    expq.delete();
    for (int i = 0; i < NE; i++) mtab[i] = '0;
    m_hit = '0; m_miss = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (3) tick();
    check("rst_no_result", res_valid, 0);
    lkp(6, 0, 0, 'hA3);
    tick(); lkp_valid = 1'b0; tick();
    check("rst_cleared_hit", res_hit, 0);
    check("rst_cleared_valid", res_valid, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
